// File: rtl/bcd_arb_pkg.sv
// rtl/bcd_arb_pkg.sv - shared constants and state encoding for the BCD converter arbiter
package bcd_arb_pkg;

    localparam int BCD_W = 12;
    localparam logic [BCD_W-1:0] BCD_ERR = 12'hFFF;
    localparam int TIMEOUT_DEFAULT = 64;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_START       = 3'd1;
    localparam logic [2:0] ST_WAIT_ACCEPT = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE   = 3'd3;
    localparam logic [2:0] ST_RESP        = 3'd4;

endpackage

// File: rtl/bcd_conv_arbiter_rr_pick.sv
// rtl/bcd_conv_arbiter_rr_pick.sv - combinational round-robin picker searching upward from a pointer
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  grant_id,
    output logic            any
);

    // First set request at ptr, ptr+1, ... with wrap; the lowest distance from ptr wins
    always_comb begin
        int idx;
        grant_id = '0;
        any      = 1'b0;
        idx      = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!any && req[idx]) begin
                any      = 1'b1;
                grant_id = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// rtl/bcd_conv_arbiter.sv - round-robin sharing of one binary-to-BCD converter; optional watchdog via BCD_ARB_TIMEOUT_EN
module bcd_conv_arbiter
    import bcd_arb_pkg::*;
#(
    parameter int N       = 9,
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] din,
    output logic [NREQ-1:0]   resp_valid,
    output logic [BCD_W-1:0]  resp_bcd,
    output logic [IDW-1:0]    resp_id,
    output logic              resp_err,
    output logic              busy,
    output logic              conv_start,
    output logic [N-1:0]      conv_in,
    input  logic              conv_ready,
    input  logic              conv_done,
    input  logic [BCD_W-1:0]  conv_bcd
);

    logic [2:0]       state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   pick_id;
    logic             pick_any;
    logic             waiting;
    logic             fin;
    logic             fin_err;
    logic [BCD_W-1:0] fin_bcd;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req      (req),
        .ptr      (ptr),
        .grant_id (pick_id),
        .any      (pick_any)
    );

    assign waiting    = (state == ST_WAIT_ACCEPT) || (state == ST_WAIT_DONE);
    assign busy       = (state != ST_IDLE);
    assign conv_start = (state == ST_START) && conv_ready;

`ifdef BCD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_cnt;
    logic          timed_out;

    // Watchdog: starts at 1 on the start pulse so it expires TIMEOUT cycles after it
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state == ST_START) begin
            wd_cnt <= CW'(1);
        end else if (waiting && (wd_cnt != CW'(TIMEOUT - 1))) begin
            wd_cnt <= wd_cnt + CW'(1);
        end
    end

    assign timed_out = waiting && (wd_cnt == CW'(TIMEOUT - 1));
    assign fin       = waiting && (conv_done || timed_out);
    assign fin_err   = waiting && !conv_done;
    assign fin_bcd   = conv_done ? conv_bcd : BCD_ERR;
`else
    assign fin     = waiting && conv_done;
    assign fin_err = 1'b0;
    assign fin_bcd = conv_bcd;
`endif

    // Arbitration FSM; response registers load on entry to RESP so the strobe lands in the RESP cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            grant_id   <= '0;
            conv_in    <= '0;
            resp_valid <= '0;
            resp_bcd   <= '0;
            resp_id    <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= '0;
            resp_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_id <= pick_id;
                        conv_in  <= din[pick_id*N +: N];
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (conv_ready) begin
                        state <= ST_WAIT_ACCEPT;
                    end
                end
                ST_WAIT_ACCEPT, ST_WAIT_DONE: begin
                    if (fin) begin
                        state <= ST_RESP;
                        // A withdrawn requester gets nothing; its result is dropped
                        if (req[grant_id]) begin
                            resp_valid <= NREQ'(1) << grant_id;
                            resp_bcd   <= fin_bcd;
                            resp_id    <= grant_id;
                            resp_err   <= fin_err;
                        end
                    end else if ((state == ST_WAIT_ACCEPT) && !conv_ready) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_RESP: begin
                    if (int'(grant_id) == NREQ - 1) begin
                        ptr <= '0;
                    end else begin
                        ptr <= grant_id + IDW'(1);
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb/tb_bcd_conv_arbiter.sv - directed self-checking bench for bcd_conv_arbiter with a behavioural converter
module tb_bcd_conv_arbiter;

    localparam int N    = 9;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] din;
    logic [NREQ-1:0]   resp_valid;
    logic [11:0]       resp_bcd;
    logic [IDW-1:0]    resp_id;
    logic              resp_err;
    logic              busy;
    logic              conv_start;
    logic [N-1:0]      conv_in;
    logic              conv_ready;
    logic              conv_done;
    logic [11:0]       conv_bcd;

    int checks   = 0;
    int failures = 0;

    bcd_conv_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .din        (din),
        .resp_valid (resp_valid),
        .resp_bcd   (resp_bcd),
        .resp_id    (resp_id),
        .resp_err   (resp_err),
        .busy       (busy),
        .conv_start (conv_start),
        .conv_in    (conv_in),
        .conv_ready (conv_ready),
        .conv_done  (conv_done),
        .conv_bcd   (conv_bcd)
    );

    always #5 clk = ~clk;

    // Converter stand-in: busy for 2N+2 cycles after accepting start, done on the last
    logic        cv_busy;
    int          cv_cnt;
    logic [11:0] cv_res;
    logic        stall;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    assign conv_ready = !cv_busy;
    assign conv_done  = cv_busy && (cv_cnt == 2 * N + 1) && !stall;
    assign conv_bcd   = cv_res;

    always @(posedge clk) begin
        if (rst) begin
            cv_busy <= 1'b0;
            cv_cnt  <= 0;
            cv_res  <= '0;
        end else if (conv_start && !cv_busy) begin
            cv_busy <= 1'b1;
            cv_cnt  <= 0;
            cv_res  <= to_bcd(int'(conv_in));
        end else if (cv_busy) begin
            if (conv_done) cv_busy <= 1'b0;
            else if (cv_cnt < 1000) cv_cnt <= cv_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int id, input int val);
        din[id*N +: N] = N'(val);
    endtask

    task automatic wait_resp(input int max, output int cyc, output logic [NREQ-1:0] vec);
        bit seen;
        seen = 1'b0;
        cyc  = max + 1;
        vec  = '0;
        for (int k = 1; k <= max; k++) begin
            if (!seen) begin
                @(negedge clk);
                if (resp_valid != '0) begin
                    seen = 1'b1;
                    cyc  = k;
                    vec  = resp_valid;
                end
            end
        end
    endtask

    task automatic quiet(input int n, output int strobes);
        strobes = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (resp_valid != '0) strobes++;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int               cyc;
    int               strobes;
    logic [NREQ-1:0]  vec;
    int               served [NREQ];
    logic [11:0]      fair_bcd [NREQ];

    initial begin
        rst   = 1'b1;
        req   = '0;
        din   = '0;
        stall = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_busy", 32'(busy), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_conv_start", 32'(conv_start), 0);
        chk("rst_resp_bcd", 32'(resp_bcd), 0);
        chk("rst_resp_id", 32'(resp_id), 0);
        chk("rst_conv_in", 32'(conv_in), 0);
        chk("rst_resp_err", 32'(resp_err), 0);

        // 1. Single request, 255 -> 0x255 after 22 cycles
        set_op(0, 255);
        req = 4'b0001;
        @(negedge clk);
        chk("t1_start_pulse", 32'(conv_start), 1);
        chk("t1_conv_in", 32'(conv_in), 255);
        wait_resp(40, cyc, vec);
        chk("t1_latency", 32'(cyc + 1), 22);
        chk("t1_vec", 32'(vec), 32'h1);
        chk("t1_bcd", 32'(resp_bcd), 32'h255);
        chk("t1_id", 32'(resp_id), 0);
        chk("t1_err", 32'(resp_err), 0);
        req = '0;
        @(negedge clk);
        chk("t1_pulse_len", 32'(resp_valid), 0);
        chk("t1_bcd_hold", 32'(resp_bcd), 32'h255);
        chk("t1_idle_busy", 32'(busy), 0);

        // 2. Boundary operands on requester 1
        set_op(1, 0);
        req = 4'b0010;
        wait_resp(40, cyc, vec);
        chk("t2_zero_lat", 32'(cyc), 22);
        chk("t2_zero_vec", 32'(vec), 32'h2);
        chk("t2_zero_bcd", 32'(resp_bcd), 32'h000);
        req = '0;
        quiet(5, strobes);
        chk("t2_no_spurious", 32'(strobes), 0);
        set_op(1, 511);
        req = 4'b0010;
        wait_resp(40, cyc, vec);
        chk("t2_max_vec", 32'(vec), 32'h2);
        chk("t2_max_bcd", 32'(resp_bcd), 32'h511);
        chk("t2_max_id", 32'(resp_id), 1);
        req = '0;
        @(negedge clk);

        // 3. Contention with pointer at 0
        pulse_reset();
        set_op(0, 7);
        set_op(2, 99);
        req = 4'b0101;
        wait_resp(40, cyc, vec);
        chk("t3_first_vec", 32'(vec), 32'h1);
        chk("t3_first_bcd", 32'(resp_bcd), 32'h007);
        req[0] = 1'b0;
        wait_resp(40, cyc, vec);
        chk("t3_second_lat", 32'(cyc), 23);
        chk("t3_second_vec", 32'(vec), 32'h4);
        chk("t3_second_bcd", 32'(resp_bcd), 32'h099);
        chk("t3_second_id", 32'(resp_id), 2);
        req = '0;
        @(negedge clk);
        set_op(1, 300);
        set_op(3, 42);
        req = 4'b1010;
        wait_resp(40, cyc, vec);
        chk("t3_third_vec", 32'(vec), 32'h8);
        chk("t3_third_bcd", 32'(resp_bcd), 32'h042);
        req[3] = 1'b0;
        wait_resp(40, cyc, vec);
        chk("t3_fourth_vec", 32'(vec), 32'h2);
        chk("t3_fourth_bcd", 32'(resp_bcd), 32'h300);
        req = '0;
        @(negedge clk);

        // 4. Fairness: all four held for 12 conversions
        pulse_reset();
        set_op(0, 1);
        set_op(1, 202);
        set_op(2, 303);
        set_op(3, 404);
        fair_bcd[0] = 12'h001;
        fair_bcd[1] = 12'h202;
        fair_bcd[2] = 12'h303;
        fair_bcd[3] = 12'h404;
        for (int k = 0; k < NREQ; k++) served[k] = 0;
        req = 4'b1111;
        for (int i = 0; i < 12; i++) begin
            wait_resp(40, cyc, vec);
            chk($sformatf("t4_order_%0d", i), 32'(vec), 32'(1 << (i % 4)));
            chk($sformatf("t4_bcd_%0d", i), 32'(resp_bcd), 32'(fair_bcd[i % 4]));
            for (int k = 0; k < NREQ; k++) if (vec[k]) served[k]++;
        end
        req = '0;
        for (int k = 0; k < NREQ; k++) chk($sformatf("t4_count_%0d", k), 32'(served[k]), 3);
        @(negedge clk);

        // 5a. Reset during WAIT_DONE aborts without a response
        set_op(0, 123);
        req = 4'b0001;
        repeat (10) @(negedge clk);
        chk("t5_mid_busy", 32'(busy), 1);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_valid", 32'(resp_valid), 0);
        quiet(25, strobes);
        chk("t5_no_resp_after_rst", 32'(strobes), 0);
        set_op(2, 456);
        req = 4'b0100;
        wait_resp(40, cyc, vec);
        chk("t5_after_rst_lat", 32'(cyc), 22);
        chk("t5_after_rst_vec", 32'(vec), 32'h4);
        chk("t5_after_rst_bcd", 32'(resp_bcd), 32'h456);
        req = '0;
        @(negedge clk);

        // 5b. Requester 1 withdraws mid-conversion; pointer still moves to 2
        set_op(1, 77);
        req = 4'b0010;
        repeat (10) @(negedge clk);
        req = '0;
        quiet(20, strobes);
        chk("t5_withdraw_no_strobe", 32'(strobes), 0);
        chk("t5_withdraw_bcd_hold", 32'(resp_bcd), 32'h456);
        set_op(2, 8);
        req = 4'b0110;
        wait_resp(40, cyc, vec);
        chk("t5_ptr_adv_vec", 32'(vec), 32'h4);
        chk("t5_ptr_adv_bcd", 32'(resp_bcd), 32'h008);
        req[2] = 1'b0;
        wait_resp(40, cyc, vec);
        chk("t5_then_1_vec", 32'(vec), 32'h2);
        chk("t5_then_1_bcd", 32'(resp_bcd), 32'h077);
        req = '0;
        @(negedge clk);

`ifdef BCD_ARB_TIMEOUT_EN
        // 6. Converter never finishes: watchdog answers with the error code
        stall = 1'b1;
        set_op(0, 5);
        req = 4'b0001;
        wait_resp(100, cyc, vec);
        chk("t6_to_lat", 32'(cyc), 65);
        chk("t6_to_vec", 32'(vec), 32'h1);
        chk("t6_to_err", 32'(resp_err), 1);
        chk("t6_to_bcd", 32'(resp_bcd), 32'hFFF);
        req = '0;
        stall = 1'b0;
        pulse_reset();
`else
        chk("t6_err_tied", 32'(resp_err), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
- Shares one iterative binary-to-BCD converter (3 BCD digits, N-bit input, start/ready/done handshake) among NREQ requesters.
- Uses round-robin arbitration.
- Latches the winner's operand, sequences one conversion, captures the 3-digit result and returns it to the winner with a one-cycle response pulse.
- Sits between the display/measurement clients and the converter instance.

Parameters:
- N, 9, operand width; legal range 4..9, so the maximum value is at most 999.
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, 2, requester index width; must be at least ceil(log2(NREQ)).
- TIMEOUT, 64, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- din  in  NREQ*N  flat operands; requester k occupies bits [k*N +: N].
- resp_valid  out  NREQ  one-hot, one-cycle result strobe.
- resp_bcd  out  12  result as {hundreds, tens, units}.
- resp_id  out  IDW  index of the requester being answered.
- resp_err  out  1  timeout flag; constant 0 when the feature is off.
- busy  out  1  high whenever the arbiter is not in IDLE.
- conv_start  out  1  converter start pulse.
- conv_in  out  N  registered operand to the converter.
- conv_ready  in  1  converter idle.
- conv_done  in  1  converter finished; result valid in this cycle.
- conv_bcd  in  12  converter digits.

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk.
  - State goes to IDLE and the round-robin pointer goes to 0.
  - resp_valid, conv_start, resp_err and busy go to 0.
  - resp_bcd, resp_id and conv_in go to 0.
  - The converter shares rst, so reset mid-conversion aborts cleanly and no response is issued.
- IDLE:
  - If any req bit is high, grant the first set bit found searching from the pointer upward with wrap (pointer first, then pointer+1, ... modulo NREQ).
  - Register grant_id and conv_in <= din slice of the granted requester, then go to START.
- START:
  - conv_start=1 for exactly one cycle, only if conv_ready=1.
  - If conv_ready=0, hold in START and keep conv_start=0.
  - Go to WAIT_ACCEPT after the pulse.
- WAIT_ACCEPT: wait for conv_ready=0 (converter has left idle), then go to WAIT_DONE.
- WAIT_DONE:
  - On conv_done=1, capture conv_bcd and go to RESP.
  - conv_in is held stable throughout.
- RESP:
  - If req[grant_id] is still high: resp_valid[grant_id]=1, resp_id=grant_id, resp_bcd=captured value.
  - Otherwise the result is discarded and no strobe is issued.
  - In both cases pointer <= grant_id+1 modulo NREQ, then go to IDLE.
- Timing and holding:
  - Latency from the IDLE cycle that sees req to resp_valid is 2N+4 cycles (22 for N=9).
  - resp_bcd and resp_id hold their values until the next RESP.
- Requester rules:
  - Hold req and din stable until the strobe.
  - Drop req in the cycle after the strobe.
  - A req still high in the next IDLE cycle is treated as a new request.
- Simultaneous requests: only one grant per IDLE cycle. The pointer rule guarantees each active requester is served within NREQ conversions.
- req changes outside IDLE are ignored until the next IDLE.

Optional Feature:
- Macro: BCD_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT_ACCEPT and WAIT_DONE.
  - When the counter reaches TIMEOUT, go to RESP with resp_err=1 for that strobe and resp_bcd=12'hFFF.
  - The pointer advances as normal.
  - resp_err is 0 on all normal responses.
- Undefined: no counter is built, resp_err is tied to 0, and the arbiter waits indefinitely for conv_done.

Decomposition:
- Shared package bcd_arb_pkg holds:
  - state encoding: IDLE, START, WAIT_ACCEPT, WAIT_DONE, RESP.
  - BCD_W=12.
  - error code 12'hFFF.
  - default TIMEOUT.
- One sub-module is natural: rr_pick, a combinational round-robin picker with inputs (req, pointer) and outputs (grant_id, any).
- Top level holds the FSM and registers.

Test Plan:
1. Single request: req[0]=1, din0=255 → resp_valid[0] exactly 22 cycles later with resp_bcd=12'h255 and resp_id=0.
2. Boundary operands: din1=0, then din1=511 → resp_bcd=12'h000, then 12'h511, with no spurious strobes in between.
3. Contention: req[0] and req[2] rise together with pointer=0, din0=7, din2=99 → first response is id 0 with 12'h007, second is id 2 with 12'h099. Then req[1] and req[3] together → id 3 is served before id 1 (pointer=3).
4. Fairness: all four requesters held high for 12 conversions → grant order is 0,1,2,3 repeated, and each id is served exactly 3 times.
5. Reset and withdrawal:
   - rst pulsed mid-WAIT_DONE → busy=0 and no resp_valid; the next request completes normally with correct digits.
   - req[1] dropped mid-conversion → no resp_valid[1], and the pointer still advances.
6. Timeout (BCD_ARB_TIMEOUT_EN, TIMEOUT=64): stub converter never raises conv_done → resp_err=1 and resp_bcd=12'hFFF, 64 cycles after the START pulse, on resp_valid of the granted requester.
